// File: rtl/mem_pkg.sv
// Shared decode constants and types for the RV64IM memory stage.
package mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lo_mask(input size_e sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_strb(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory port: store strobes/data and
// load data alignment with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [7:0]  strb,
  output logic [63:0] wdata_sh,
  output logic [63:0] ldata
);

  logic [5:0]  sh;
  logic [63:0] raw;

  assign sh       = {addr_lo, 3'b000};
  assign strb     = size_strb(size) << addr_lo;
  assign wdata_sh = wdata << sh;
  assign raw      = rdata >> sh;

  always_comb begin
    ldata = raw;
    case (size)
      SZ_B:    ldata = is_unsigned ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    ldata = is_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    ldata = is_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: ldata = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64IM pipeline memory stage: req/ack data memory access, upstream stall,
// registered WB bundle. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_RES,
  input  logic [63:0] MEM_Address,
  input  logic [63:0] MEM_RFD,
  input  logic [63:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  output logic [7:0]  DMEM_WSTRB,
  output logic        V_MEM_STALL,
  output logic        WB_V,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_RES,
  output logic [4:0]  WB_DR,
  output logic        WB_EXC,
  output logic [1:0]  WB_CAUSE
);

  import mem_pkg::*;

  localparam logic [15:0] TMO = 16'(ACK_TIMEOUT);

  state_e      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op, misalign, trap, tmo_hit;
  size_e       size;
  logic [2:0]  off;
  logic [7:0]  strb;
  logic [63:0] wdata_sh, ldata;

  assign funct3   = MEM_IR[14:12];
  assign is_load  = (MEM_IR[6:0] == OPC_LOAD);
  assign is_store = (MEM_IR[6:0] == OPC_STORE);
  assign mem_op   = MEM_V & (is_load | is_store);
  assign size     = size_e'(funct3[1:0]);
  assign misalign = |(MEM_Address[2:0] & size_lo_mask(size));
  assign off      = MEM_Address[2:0] & ~size_lo_mask(size);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & misalign;
`else
  assign trap = 1'b0;
`endif

  assign V_MEM_STALL = mem_op & ~trap & (state != ST_DONE);
  assign WB_DR       = WB_IR[11:7];
  // Fires on the BUSY edge that would complete the ACK_TIMEOUT-th ACK-less cycle.
  assign tmo_hit     = (TMO != '0) && ((tmo_cnt + 16'd1) == TMO);

  mem_lane_align u_align (
    .addr_lo     (off),
    .size        (size),
    .is_unsigned (funct3[2]),
    .rdata       (DMEM_RDATA),
    .wdata       (MEM_RFD),
    .strb        (strb),
    .wdata_sh    (wdata_sh),
    .ldata       (ldata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      DMEM_REQ   <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
      DMEM_WSTRB <= '0;
      WB_V       <= 1'b0;
      WB_IR      <= '0;
      WB_NPC     <= '0;
      WB_RES     <= '0;
      WB_EXC     <= 1'b0;
      WB_CAUSE   <= CAUSE_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op && !trap) begin
            DMEM_ADDR  <= {MEM_Address[63:3], 3'b000};
            DMEM_WE    <= is_store;
            DMEM_WDATA <= wdata_sh;
            DMEM_WSTRB <= strb;
            DMEM_REQ   <= 1'b1;
            tmo_cnt    <= '0;
            WB_V       <= 1'b0;
            state      <= ST_BUSY;
          end else begin
            WB_V     <= MEM_V;
            WB_IR    <= MEM_IR;
            WB_NPC   <= MEM_NPC;
            WB_RES   <= trap ? MEM_Address : MEM_RES;
            WB_EXC   <= trap;
            WB_CAUSE <= trap ? CAUSE_MISALIGN : CAUSE_NONE;
          end
        end
        ST_BUSY: begin
          if (DMEM_ACK) begin
            DMEM_REQ <= 1'b0;
            WB_V     <= 1'b1;
            WB_IR    <= MEM_IR;
            WB_NPC   <= MEM_NPC;
            WB_RES   <= is_load ? ldata : MEM_Address;
            WB_EXC   <= 1'b0;
            WB_CAUSE <= CAUSE_NONE;
            state    <= ST_DONE;
          end else if (tmo_hit) begin
            DMEM_REQ <= 1'b0;
            WB_V     <= 1'b1;
            WB_IR    <= MEM_IR;
            WB_NPC   <= MEM_NPC;
            WB_RES   <= MEM_Address;
            WB_EXC   <= 1'b1;
            WB_CAUSE <= CAUSE_TIMEOUT;
            state    <= ST_DONE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          WB_V  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-level reference model, per-cycle
// compare of DMEM request fields and WB bundle, plus literal spot checks.
module tb_mem_stage;

  localparam int TMO = 6;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] res;
    logic        exc;
    logic [1:0]  cause;
  } wb_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC, MEM_RES, MEM_Address, MEM_RFD, DMEM_RDATA;
  logic        DMEM_ACK;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        V_MEM_STALL;
  logic        WB_V;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_RES;
  logic [4:0]  WB_DR;
  logic        WB_EXC;
  logic [1:0]  WB_CAUSE;

  int checks = 0;
  int errors = 0;

  wb_t         exp_q[$];
  logic        exp_mem = 1'b0;
  logic        exp_we;
  logic [63:0] exp_addr, exp_wdata;
  logic [7:0]  exp_strb;
  int          exp_req_n, exp_stall_n;
  logic [63:0] npc_ctr = 64'h8000_0000;

  logic [63:0] last_res, last_daddr, last_wdata;
  logic [7:0]  last_strb;
  logic        last_exc, last_we;
  logic [1:0]  last_cause;

  mem_stage #(.ACK_TIMEOUT(TMO)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_V       (MEM_V),
    .MEM_IR      (MEM_IR),
    .MEM_NPC     (MEM_NPC),
    .MEM_RES     (MEM_RES),
    .MEM_Address (MEM_Address),
    .MEM_RFD     (MEM_RFD),
    .DMEM_RDATA  (DMEM_RDATA),
    .DMEM_ACK    (DMEM_ACK),
    .DMEM_REQ    (DMEM_REQ),
    .DMEM_WE     (DMEM_WE),
    .DMEM_ADDR   (DMEM_ADDR),
    .DMEM_WDATA  (DMEM_WDATA),
    .DMEM_WSTRB  (DMEM_WSTRB),
    .V_MEM_STALL (V_MEM_STALL),
    .WB_V        (WB_V),
    .WB_IR       (WB_IR),
    .WB_NPC      (WB_NPC),
    .WB_RES      (WB_RES),
    .WB_DR       (WB_DR),
    .WB_EXC      (WB_EXC),
    .WB_CAUSE    (WB_CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, opc};
  endfunction

  // Reference behaviour: byte-by-byte lane placement; d<0 means no ACK ever.
  task automatic model(input logic v, input logic [31:0] ir, input logic [63:0] npc,
                       input logic [63:0] addr, input logic [63:0] rfd, input logic [63:0] res,
                       input logic [63:0] rdata, input int d, input bit push);
    wb_t         e;
    int unsigned nb, off;
    bit          ld, st, mem, trap, tmo;
    logic [63:0] val;
    ld   = (ir[6:0] == 7'b0000011);
    st   = (ir[6:0] == 7'b0100011);
    mem  = v && (ld || st);
    nb   = 1 << ir[13:12];
    off  = int'(addr[2:0]);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem && ((off % nb) != 0);
`else
    off = off - (off % nb);
`endif
    tmo       = mem && !trap && (d < 0 || d >= TMO);
    exp_mem   = mem && !trap;
    exp_addr  = {addr[63:3], 3'b000};
    exp_we    = st;
    exp_strb  = '0;
    exp_wdata = '0;
    for (int unsigned i = 0; i < nb; i++)
      if (off + i < 8) exp_strb[off+i] = 1'b1;
    for (int unsigned b = off; b < 8; b++)
      exp_wdata[8*b +: 8] = rfd[8*(b-off) +: 8];
    val = '0;
    for (int unsigned i = 0; i < nb; i++)
      if (off + i < 8) val[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!ir[14] && nb < 8 && val[8*nb-1])
      for (int unsigned i = nb; i < 8; i++) val[8*i +: 8] = 8'hFF;
    exp_req_n   = exp_mem ? (tmo ? TMO : d + 1) : 0;
    exp_stall_n = exp_mem ? exp_req_n + 1 : 0;
    e.ir  = ir;
    e.npc = npc;
    if (trap)     begin e.res = addr;             e.exc = 1'b1; e.cause = 2'd1; end
    else if (tmo) begin e.res = addr;             e.exc = 1'b1; e.cause = 2'd2; end
    else if (mem) begin e.res = ld ? val : addr;  e.exc = 1'b0; e.cause = 2'd0; end
    else          begin e.res = res;              e.exc = 1'b0; e.cause = 2'd0; end
    if (v && push) exp_q.push_back(e);
  endtask

  // Presents one instruction, plays memory with ACK after d REQ cycles,
  // holds it until the stage stops stalling, then inserts a bubble.
  task automatic issue(input logic v, input logic [31:0] ir, input logic [63:0] addr,
                       input logic [63:0] rfd, input logic [63:0] res, input logic [63:0] rdata,
                       input int d);
    int req_n, stall_n;
    bit done;
    req_n = 0; stall_n = 0; done = 1'b0;
    @(negedge CLK);
    npc_ctr     = npc_ctr + 64'd4;
    MEM_V       = v;
    MEM_IR      = ir;
    MEM_NPC     = npc_ctr;
    MEM_RES     = res;
    MEM_Address = addr;
    MEM_RFD     = rfd;
    DMEM_RDATA  = rdata;
    model(v, ir, npc_ctr, addr, rfd, res, rdata, d, 1'b1);
    #1;
    for (int c = 0; c < 64; c++) begin
      DMEM_ACK = 1'b0;
      if (DMEM_REQ) begin
        if (req_n == d) DMEM_ACK = 1'b1;
        req_n++;
      end
      if (!V_MEM_STALL) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      @(negedge CLK);
      #1;
    end
    chk("stall_bound", 64'(done), 64'd1);
    chk("req_cycles", 64'(req_n), 64'(exp_req_n));
    chk("stall_cycles", 64'(stall_n), 64'(exp_stall_n));
    @(negedge CLK);
    MEM_V    = 1'b0;
    exp_mem  = 1'b0;
    DMEM_ACK = 1'b0;
    #3;
  endtask

  // Compare process: DMEM request fields and WB bundle against the model.
  always @(negedge CLK) begin
    #2;
    if (!RESET) begin
      if (!exp_mem) chk("no_req", 64'(DMEM_REQ), 64'd0);
      else if (DMEM_REQ) begin
        chk("dmem_addr", DMEM_ADDR, exp_addr);
        chk("dmem_we", 64'(DMEM_WE), 64'(exp_we));
        chk("dmem_wstrb", 64'(DMEM_WSTRB), 64'(exp_strb));
        if (exp_we) chk("dmem_wdata", DMEM_WDATA, exp_wdata);
        last_daddr = DMEM_ADDR;
        last_we    = DMEM_WE;
        last_strb  = DMEM_WSTRB;
        last_wdata = DMEM_WDATA;
      end
      if (exp_q.size() == 0) chk("no_wb", 64'(WB_V), 64'd0);
      else if (WB_V) begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_ir", 64'(WB_IR), 64'(e.ir));
        chk("wb_npc", WB_NPC, e.npc);
        chk("wb_res", WB_RES, e.res);
        chk("wb_dr", 64'(WB_DR), 64'(e.ir[11:7]));
        chk("wb_exc", 64'(WB_EXC), 64'(e.exc));
        chk("wb_cause", 64'(WB_CAUSE), 64'(e.cause));
        last_res   = WB_RES;
        last_exc   = WB_EXC;
        last_cause = WB_CAUSE;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; MEM_V = 1'b0; MEM_IR = '0; MEM_NPC = '0; MEM_RES = '0;
    MEM_Address = '0; MEM_RFD = '0; DMEM_RDATA = '0; DMEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_we", 64'(DMEM_WE), 64'd0);
    chk("rst_wstrb", 64'(DMEM_WSTRB), 64'd0);
    chk("rst_wb_v", 64'(WB_V), 64'd0);
    chk("rst_wb_exc", 64'(WB_EXC), 64'd0);
    chk("rst_wb_cause", 64'(WB_CAUSE), 64'd0);
    RESET = 1'b0;

    // ADD pass-through
    issue(1'b1, mk_ir(7'b0110011, 3'b000, 5'd3), 64'h0, 64'h0, 64'h42, 64'h0, 0);
    chk("lit_add_res", last_res, 64'h42);
    // LB / LBU at 0x1003
    issue(1'b1, mk_ir(7'b0000011, 3'b000, 5'd5), 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 0);
    chk("lit_lb_res", last_res, 64'hFFFF_FFFF_FFFF_FF80);
    issue(1'b1, mk_ir(7'b0000011, 3'b100, 5'd6), 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 2);
    chk("lit_lbu_res", last_res, 64'h0000_0000_0000_0080);
    // SH at 0x2002
    issue(1'b1, mk_ir(7'b0100011, 3'b001, 5'd0), 64'h2002, 64'h1234_ABCD, 64'h0, 64'h0, 1);
    chk("lit_sh_addr", last_daddr, 64'h2000);
    chk("lit_sh_we", 64'(last_we), 64'd1);
    chk("lit_sh_strb", 64'(last_strb), 64'h0C);
    chk("lit_sh_wdata", 64'(last_wdata[31:16]), 64'hABCD);
    chk("lit_sh_res", last_res, 64'h2002);
    // LD with slow ACK (just inside the timeout)
    issue(1'b1, mk_ir(7'b0000011, 3'b011, 5'd7), 64'h3008, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 5);
    chk("lit_ld_res", last_res, 64'h0123_4567_89AB_CDEF);
    // More widths and lanes
    issue(1'b1, mk_ir(7'b0000011, 3'b001, 5'd8), 64'h1006, 64'h0, 64'h0, 64'h8001_0000_0000_0000, 0);
    issue(1'b1, mk_ir(7'b0000011, 3'b110, 5'd9), 64'h1004, 64'h0, 64'h0, 64'hF000_0000_1111_1111, 3);
    chk("lit_lwu_res", last_res, 64'h0000_0000_F000_0000);
    issue(1'b1, mk_ir(7'b0000011, 3'b010, 5'd10), 64'h1004, 64'h0, 64'h0, 64'hF000_0000_1111_1111, 0);
    issue(1'b1, mk_ir(7'b0000011, 3'b111, 5'd11), 64'h1000, 64'h0, 64'h0, 64'hFEDC_BA98_7654_3210, 0);
    issue(1'b1, mk_ir(7'b0100011, 3'b000, 5'd0), 64'h2007, 64'hAB, 64'h0, 64'h0, 0);
    chk("lit_sb_strb", 64'(last_strb), 64'h80);
    issue(1'b1, mk_ir(7'b0100011, 3'b010, 5'd0), 64'h2004, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 64'h0, 2);
    issue(1'b1, mk_ir(7'b0100011, 3'b011, 5'd0), 64'h2000, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 0);
    issue(1'b1, mk_ir(7'b0000011, 3'b010, 5'd12), 64'h1002, 64'h0, 64'h0, 64'h89AB_CDEF_8765_4321, 0);
    // Invalid slot with load opcode, then a non-memory op
    issue(1'b0, mk_ir(7'b0000011, 3'b011, 5'd13), 64'h4000, 64'h0, 64'h0, 64'h0, 0);
    issue(1'b1, mk_ir(7'b0110011, 3'b110, 5'd14), 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);

    // Reset while BUSY, then a late ACK
    @(negedge CLK);
    npc_ctr = npc_ctr + 64'd4;
    MEM_V = 1'b1; MEM_IR = mk_ir(7'b0000011, 3'b011, 5'd15); MEM_NPC = npc_ctr;
    MEM_Address = 64'h5000; DMEM_RDATA = 64'h5555;
    model(1'b1, MEM_IR, npc_ctr, 64'h5000, 64'h0, 64'h0, 64'h5555, -1, 1'b0);
    @(negedge CLK);
    #1;
    chk("rst_busy_req", 64'(DMEM_REQ), 64'd1);
    RESET = 1'b1; MEM_V = 1'b0;
    @(negedge CLK);
    #1;
    exp_mem = 1'b0;
    chk("rst_abort_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_abort_wb_v", 64'(WB_V), 64'd0);
    RESET = 1'b0; DMEM_ACK = 1'b1;
    @(negedge CLK);
    #1;
    DMEM_ACK = 1'b0;
    chk("late_ack_req", 64'(DMEM_REQ), 64'd0);
    chk("late_ack_wb_v", 64'(WB_V), 64'd0);
    issue(1'b1, mk_ir(7'b0000011, 3'b011, 5'd16), 64'h5000, 64'h0, 64'h0, 64'h0000_0000_0000_5555, 0);
    chk("lit_post_rst_res", last_res, 64'h5555);

    // No ACK: bus timeout after TMO BUSY cycles
    issue(1'b1, mk_ir(7'b0000011, 3'b011, 5'd17), 64'h6008, 64'h0, 64'h0, 64'h0, -1);
    chk("lit_tmo_exc", 64'(last_exc), 64'd1);
    chk("lit_tmo_cause", 64'(last_cause), 64'd2);
    chk("lit_tmo_res", last_res, 64'h6008);
    issue(1'b1, mk_ir(7'b0110011, 3'b000, 5'd18), 64'h0, 64'h0, 64'h99, 64'h0, 0);
    chk("lit_exc_clear", 64'(last_exc), 64'd0);

    repeat (3) @(negedge CLK);
    #3;
    chk("wb_missing", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage of the RV64IM core. Consumes the registered MEM_* bundle produced by the execute stage.
- Performs loads and stores against a single-port data memory using a req/ack handshake.
- Aligns and extends load data and lane-shifts store data.
- Stalls upstream while an access is outstanding, then presents a registered WB_* bundle to writeback.

Parameters:
- ACK_TIMEOUT, 0, BUSY cycles allowed without DMEM_ACK before abort; 0 = wait forever (counter 16 bits, saturating).

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- MEM_V  in  1  instruction valid
- MEM_IR  in  32  instruction word
- MEM_NPC  in  64  next PC of instruction
- MEM_RES  in  64  ALU result (non-memory ops)
- MEM_Address  in  64  effective address for load/store
- MEM_RFD  in  64  store data (rs2 value)
- DMEM_RDATA  in  64  read data, valid with DMEM_ACK
- DMEM_ACK  in  1  access complete, one-cycle pulse
- DMEM_REQ  out  1  request, held until ACK
- DMEM_WE  out  1  1 = store
- DMEM_ADDR  out  64  doubleword-aligned address, {addr[63:3],3'b000}
- DMEM_WDATA  out  64  lane-shifted store data
- DMEM_WSTRB  out  8  byte enables
- V_MEM_STALL  out  1  combinational, hold upstream registers
- WB_V  out  1  writeback valid
- WB_IR  out  32  instruction word
- WB_NPC  out  64  next PC
- WB_RES  out  64  result / load data / fault address
- WB_DR  out  5  WB_IR[11:7]
- WB_EXC  out  1  exception flag
- WB_CAUSE  out  2  0 none, 1 misaligned, 2 bus timeout

Behaviour:
- Reset is RESET, synchronous, active-high; clock is CLK.
- Reset values: state IDLE, DMEM_REQ/DMEM_WE 0, DMEM_WSTRB 0, WB_V 0, WB_EXC 0, WB_CAUSE 0, timeout counter 0. Other outputs are don't-care.
- Decode: load = MEM_IR[6:0]==0000011; store = MEM_IR[6:0]==0100011. size = funct3[1:0] (B/H/W/D); unsigned = funct3[2] (loads only). mem_op = MEM_V & (load|store).
- Non-memory op: 1-cycle pass-through.
  - WB_V<=MEM_V, WB_RES<=MEM_RES, WB_IR/WB_NPC copied, WB_EXC<=0.
  - No stall, DMEM_REQ stays 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if mem_op, register DMEM_ADDR/WE/WDATA/WSTRB, set DMEM_REQ<=1, go BUSY, WB_V<=0.
  - BUSY: DMEM_REQ and all DMEM_* outputs held stable. On DMEM_ACK: DMEM_REQ<=0, load WB_* (WB_V<=1), go DONE.
  - BUSY, timeout: if ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT with no ACK: DMEM_REQ<=0, WB_V<=1, WB_EXC<=1, WB_CAUSE<=2, WB_RES<=MEM_Address, go DONE.
  - DONE: WB_V<=0, go IDLE. Upstream advances at the end of this cycle.
  - Minimum memory-op latency: issue edge, ACK edge (WB_V high for exactly one cycle), DONE edge.
- V_MEM_STALL = mem_op & (state != DONE).
- Store lanes, with o = addr[2:0]:
  - DMEM_WSTRB = (size mask 0x01/0x03/0x0F/0xFF) << o.
  - DMEM_WDATA = MEM_RFD << (8*o).
  - Bytes shifted past bit 63 are dropped.
- Load data: raw = DMEM_RDATA >> (8*o); keep low 8/16/32/64 bits; sign-extend unless funct3[2]. funct3 011/111 with funct3[2]=1 (LDU) is treated as LD.
- Store WB: WB_V=1, WB_RES=MEM_Address.
- DMEM_ACK in IDLE or DONE is ignored.
- RESET in BUSY: next cycle DMEM_REQ=0, WB_V=0, state IDLE; a late ACK is ignored.
- MEM_V=0 never issues a request and never stalls.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned address (addr & (bytes-1) != 0) issues no DMEM request and no stall.
  - 1-cycle WB with WB_V=1, WB_EXC=1, WB_CAUSE=1, WB_RES=MEM_Address.
- Undefined:
  - The address is forced to natural alignment (low log2(bytes) bits cleared) before lane computation.
  - Cause 1 is never produced.

Decomposition:
- Shared package mem_pkg:
  - opcode constants OPC_LOAD/OPC_STORE.
  - funct3 size enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - cause enum (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_TIMEOUT).
  - FSM state typedef.
- One sub-module: mem_lane_align, combinational. Inputs: addr[2:0], size, unsigned, rdata, wdata. Outputs: strb, shifted wdata, extended load data. Instanced once.

Test Plan:
1. LB at 0x1003, RDATA 0x0000_0000_8000_0000 -> WB_RES 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x0000_0000_0000_0080.
2. SH at 0x2002, MEM_RFD 0x1234_ABCD -> DMEM_ADDR 0x2000, WE=1, WSTRB 0b0000_1100, WDATA[31:16]=0xABCD.
3. LD with ACK delayed 5 cycles -> DMEM_REQ/ADDR stable 5 cycles, V_MEM_STALL high until DONE, exactly one WB_V pulse.
4. ADD, MEM_RES 0x42 -> WB_RES 0x42 next cycle, no stall, DMEM_REQ never asserted.
5. RESET during BUSY, then ACK -> DMEM_REQ 0 next cycle, WB_V stays 0, next load issues normally.
6. ACK_TIMEOUT=4, no ACK -> WB_EXC=1, WB_CAUSE=2 after 4 BUSY cycles. With macro: LW at 0x1002 -> WB_CAUSE=1, no DMEM_REQ.
